// File: rtl/minimac2_tx.sv
// minimac2 transmit engine: streams a frame from the TX buffer RAM onto MII as
// preamble/SFD followed by data nibbles, then holds off for the inter-frame gap.
module minimac2_tx (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        tx_start,
  input  logic [10:0] tx_count,
  output logic        tx_done,
  output logic [10:0] txb_adr,
  input  logic [7:0]  txb_dat,
  input  logic        tx_ce,
  output logic        phy_tx_en,
  output logic [3:0]  phy_tx_data
);

  // state    | meaning
  // ---------+--------------------------------------------------
  // IDLE     | waiting for tx_start with a non-zero byte count
  // PREAMBLE | 15 x 0x5 nibbles then the 0xD SFD nibble
  // DATA     | one byte per two strobes, low nibble first
  // IFG      | 24 strobes with phy_tx_en low, then tx_done
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    IFG      = 2'd3
  } state_t;

  state_t      state;
  logic [10:0] remaining;
  logic [3:0]  pre_cnt;
  logic        phase;
  logic [4:0]  ifg_cnt;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      remaining   <= 11'd0;
      pre_cnt     <= 4'd0;
      phase       <= 1'b0;
      ifg_cnt     <= 5'd0;
      txb_adr     <= 11'd0;
      tx_done     <= 1'b0;
      phy_tx_en   <= 1'b0;
      phy_tx_data <= 4'd0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start && (tx_count != 11'd0)) begin
            remaining <= tx_count;
            txb_adr   <= 11'd0;
            pre_cnt   <= 4'd15;
            state     <= PREAMBLE;
          end
        end

        PREAMBLE: begin
          if (tx_ce) begin
            phy_tx_en <= 1'b1;
            if (pre_cnt == 4'd0) begin
              phy_tx_data <= 4'hD;
              phase       <= 1'b0;
              state       <= DATA;
            end else begin
              phy_tx_data <= 4'h5;
              pre_cnt     <= pre_cnt - 4'd1;
            end
          end
        end

        DATA: begin
          // txb_adr only moves on the high nibble; the strobe spacing gives
          // the synchronous RAM time to present the next byte.
          if (tx_ce) begin
            if (!phase) begin
              phy_tx_data <= txb_dat[3:0];
              phase       <= 1'b1;
            end else begin
              phy_tx_data <= txb_dat[7:4];
              phase       <= 1'b0;
              txb_adr     <= txb_adr + 11'd1;
              remaining   <= remaining - 11'd1;
              if (remaining == 11'd1) begin
                ifg_cnt <= 5'd23;
                state   <= IFG;
              end
            end
          end
        end

        IFG: begin
          if (tx_ce) begin
            phy_tx_en   <= 1'b0;
            phy_tx_data <= 4'd0;
            if (ifg_cnt == 5'd0) begin
              tx_done <= 1'b1;
              state   <= IDLE;
            end else begin
              ifg_cnt <= ifg_cnt - 5'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minimac2_tx.sv
// Self-checking bench for minimac2_tx: a RAM model feeds frames, a monitor
// collects MII nibbles, and each frame is compared with its ideal nibble stream.
module tb_minimac2_tx;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        tx_start;
  logic [10:0] tx_count;
  logic        tx_done;
  logic [10:0] txb_adr;
  logic [7:0]  txb_dat;
  logic        tx_ce;
  logic        phy_tx_en;
  logic [3:0]  phy_tx_data;

  minimac2_tx dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .tx_start    (tx_start),
    .tx_count    (tx_count),
    .tx_done     (tx_done),
    .txb_adr     (txb_adr),
    .txb_dat     (txb_dat),
    .tx_ce       (tx_ce),
    .phy_tx_en   (phy_tx_en),
    .phy_tx_data (phy_tx_data)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0] ram [2048];
  logic [3:0] exp_q [$];
  logic [3:0] got_q [$];
  int         done_cnt;
  int         ifg_ce;
  int         ifg_at_done;
  int         last_adr;
  int         ce_period;
  int         ce_cnt;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) txb_dat <= ram[txb_adr];

  // nibble strobe, one sys_clk wide every ce_period cycles
  initial begin
    tx_ce  = 1'b0;
    ce_cnt = 0;
    forever begin
      @(negedge sys_clk);
      if (ce_cnt == 0) begin
        tx_ce  = 1'b1;
        ce_cnt = ce_period - 1;
      end else begin
        tx_ce  = 1'b0;
        ce_cnt = ce_cnt - 1;
      end
    end
  end

  // MII monitor: one nibble per strobe while enabled, IFG strobes counted after
  initial begin
    logic        ce_s;
    logic [10:0] adr_s;
    done_cnt    = 0;
    ifg_ce      = 0;
    ifg_at_done = 0;
    last_adr    = -1;
    forever begin
      @(posedge sys_clk);
      ce_s  = tx_ce;
      adr_s = txb_adr;
      #1;
      if (ce_s) begin
        if (phy_tx_en) begin
          got_q.push_back(phy_tx_data);
          last_adr = int'(adr_s);
          ifg_ce   = 0;
        end else begin
          ifg_ce++;
        end
      end
      if (tx_done) begin
        done_cnt++;
        ifg_at_done = ifg_ce;
      end
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic build_expected(input int n);
    exp_q.delete();
    for (int i = 0; i < 15; i++) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(ram[i][3:0]);
      exp_q.push_back(ram[i][7:4]);
    end
  endtask

  task automatic pulse_start(input int n);
    @(negedge sys_clk);
    tx_start = 1'b1;
    tx_count = 11'(n);
    @(negedge sys_clk);
    tx_start = 1'b0;
    tx_count = 11'($urandom);
  endtask

  task automatic start_frame(input int n);
    build_expected(n);
    got_q.delete();
    done_cnt    = 0;
    ifg_at_done = 0;
    last_adr    = -1;
    pulse_start(n);
  endtask

  task automatic wait_nibbles(input int k);
    int waited = 0;
    while (got_q.size() < k && waited < 20000) begin
      @(posedge sys_clk);
      waited++;
    end
    check_val("wait_nibbles_timeout", int'(got_q.size() >= k), 1);
  endtask

  task automatic finish_frame(input int n);
    int  budget;
    int  waited = 0;
    bit  bad;
    budget = (48 + 2 * n) * ce_period + 40;
    while (done_cnt == 0 && waited < budget) begin
      @(posedge sys_clk);
      waited++;
    end
    check_val("done_timeout", int'(done_cnt != 0), 1);
    repeat (3) @(posedge sys_clk);
    #1;
    check_val("nibble_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      bad = (got_q[i] !== exp_q[i]);
      check_val($sformatf("nibble[%0d]", i), int'(got_q[i]), int'(exp_q[i]));
      if (bad) break;
    end
    check_val("done_pulses", done_cnt, 1);
    check_val("ifg_strobes", ifg_at_done, 24);
    check_val("last_read_adr", last_adr, n - 1);
    check_val("final_adr", int'(txb_adr), n & 2047);
    check_val("idle_en", int'(phy_tx_en), 0);
    check_val("idle_data", int'(phy_tx_data), 0);
    check_val("done_low", int'(tx_done), 0);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) ram[i] = 8'($urandom);
  endtask

  task automatic fill_index(input int n);
    for (int i = 0; i < n; i++) ram[i] = 8'(i);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    tx_start  = 1'b0;
    tx_count  = 11'd0;
    ce_period = 4;
    for (int i = 0; i < 2048; i++) ram[i] = 8'd0;
    repeat (4) @(posedge sys_clk);
    #1;
    check_val("rst_en", int'(phy_tx_en), 0);
    check_val("rst_data", int'(phy_tx_data), 0);
    check_val("rst_adr", int'(txb_adr), 0);
    check_val("rst_done", int'(tx_done), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (5) @(posedge sys_clk);

    // single byte, slow strobe
    ram[0] = 8'hA7;
    start_frame(1);
    finish_frame(1);

    // 64 bytes at minimum strobe spacing
    ce_period = 2;
    fill_index(64);
    start_frame(64);
    finish_frame(64);

    // zero-length start is ignored
    got_q.delete();
    done_cnt = 0;
    pulse_start(0);
    repeat (200) @(posedge sys_clk);
    #1;
    check_val("zero_nibbles", got_q.size(), 0);
    check_val("zero_done", done_cnt, 0);
    check_val("zero_en", int'(phy_tx_en), 0);
    ce_period = 3;
    fill_random(2);
    start_frame(2);
    finish_frame(2);

    // start during DATA must not disturb the running frame
    fill_random(3);
    start_frame(3);
    wait_nibbles(17);
    pulse_start(5);
    finish_frame(3);
    repeat (20) @(posedge sys_clk);
    check_val("no_extra_frame", done_cnt, 1);

    // reset mid-frame at byte 10
    ce_period = 2;
    fill_random(60);
    start_frame(60);
    wait_nibbles(16 + 20);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    check_val("midrst_en", int'(phy_tx_en), 0);
    check_val("midrst_adr", int'(txb_adr), 0);
    check_val("midrst_done", int'(tx_done), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (150) @(posedge sys_clk);
    check_val("midrst_no_done", done_cnt, 0);
    fill_random(4);
    start_frame(4);
    finish_frame(4);

    // randomized frames
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(80, 1);
      ce_period = $urandom_range(6, 2);
      fill_random(n);
      start_frame(n);
      finish_frame(n);
    end

    // longest frame
    ce_period = 2;
    fill_index(2047);
    start_frame(2047);
    finish_frame(2047);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
